alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised execute stage: merges ALU-control decode with the datapath and adds an iterative
//  RV32M multiply/divide path. Accepts one operation per valid/ready handshake from the
//  decode/issue stage and returns a registered result to writeback.
//  Single-cycle ops complete in 1 cycle. MUL*/DIV*/REM* run multi-cycle behind the same handshake.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, power of 2); shift amount = op_b[$clog2(XLEN)-1:0]
//  M_EXT  1   1: funct7=0000001 selects mul/div group; 0: that group is illegal
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operation present on inputs
//  in_ready   out  1     unit can accept this cycle
//  alu_op     in   2     00 load/store add, 01 branch sub, 10 R-type, 11 I-type arith
//  funct7     in   7     instr[31:25]
//  funct3     in   3     instr[14:12]
//  op_a       in   XLEN  rs1 value
//  op_b       in   XLEN  rs2 value or immediate
//  out_valid  out  1     result/zero/illegal valid
//  out_ready  in   1     writeback accepts result
//  result     out  XLEN  operation result
//  zero       out  1     result == 0
//  illegal    out  1     undecodable alu_op/funct7/funct3; result forced to 0
//  busy       out  1     multi-cycle operation in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, zero=0, illegal=0, busy=0; reset aborts an in-flight op.
//  Decode alu_op=10, funct7=0000000, by funct3: 000 add, 001 sll, 010 slt, 011 sltu,
//   100 xor, 101 srl, 110 or, 111 and.
//  Decode alu_op=10, funct7=0100000: 000 sub, 101 sra; other funct3 illegal.
//  Decode alu_op=10, funct7=0000001: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//   100 div, 101 divu, 110 rem, 111 remu.
//  alu_op=10, any other funct7: illegal.
//  alu_op=11: as funct7=0000000 row, funct7 ignored except funct3=101 (funct7[5]=1 -> sra).
//  alu_op=00 -> add; alu_op=01 -> sub. funct7/funct3 ignored for both.
//  Handshake: transfer at edge with in_valid&&in_ready. in_ready = IDLE && (!out_valid || out_ready).
//  Output registers hold stable while out_valid && !out_ready; out_valid drops on out_ready edge
//   unless a new result loads the same edge.
//  Latency, accept edge t: single-cycle ops and illegal -> out_valid from edge t+1.
//  MUL group: XLEN shift-add iterations + 1 finish cycle; out_valid at edge t+XLEN+1.
//  DIV/REM: restoring, XLEN iterations + 1 sign-fix cycle; out_valid at edge t+XLEN+1.
//  FSM: IDLE -> MUL or DIV on accept of M op; MUL/DIV -> FIN after XLEN iterations;
//   FIN -> IDLE, loading output. Single-cycle ops stay in IDLE. busy=1 in MUL/DIV/FIN.
//  Arithmetic: wrap mod 2^XLEN. mulh* return bits [2*XLEN-1:XLEN] of the signed/unsigned product;
//   mulhsu: op_a signed, op_b unsigned.
//  Division by zero is a fast path, 1-cycle latency: quotient = all ones; remainder = op_a.
//  Signed overflow (op_a=MIN, op_b=-1) is a fast path, 1-cycle latency: quotient = MIN, remainder = 0.
//  Remainder sign follows dividend. zero is computed from the final result; illegal ops give zero=1.
//  Inputs are sampled only at accept; changes during MUL/DIV have no effect.
// TESTING
//  alu_op=00, a=5, b=7, out_ready=1 -> result=12, zero=0, out_valid 1 cycle after accept.
//  alu_op=01, a=b=0x1234 -> result=0, zero=1. alu_op=10, f7=0100000, f3=101, a=0x80000000, b=4
//   -> result=0xF8000000.
//  mulh: a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFF, out_valid exactly 33 cycles after accept;
//   in_ready=0, busy=1 throughout.
//  div: a=-7, b=2 -> -3; rem -> -1. divu b=0 -> 0xFFFFFFFF in 1 cycle. div 0x80000000/-1 -> 0x80000000.
//  Backpressure: out_ready=0 for 5 cycles after a result -> result/out_valid stable, in_ready=0;
//   next op accepted on release edge.
//  rst_n low mid-div (cycle 10) -> out_valid=0, busy=0 immediately; M_EXT=0 with funct7=0000001
//   -> illegal=1, result=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, single-cycle integer datapath and an
// iterative RV32M multiply/divide unit behind one valid/ready handshake.
// The result, zero and illegal outputs are registered and held under backpressure.
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SW-1:0]   LAST_ITER = SW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    // M-extension ops are encoded as {2'b10, funct3} so the group decodes directly.
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL    = 5'd2,  OP_SLT   = 5'd3,
        OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7,
        OP_OR   = 5'd8,  OP_AND  = 5'd9,
        OP_MUL  = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19,
        OP_DIV  = 5'd20, OP_DIVU = 5'd21, OP_REM    = 5'd22, OP_REMU  = 5'd23
    } op_t;

    function automatic op_t base_op(input logic [2:0] f3, input logic arith);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return arith ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    state_t             state;
    op_t                op_q;
    logic [SW-1:0]      iter;
    logic [2*XLEN-1:0]  acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]    opnd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic               neg_res;  // negate product / quotient at finish
    logic               neg_rem;  // negate remainder at finish (follows dividend)

    op_t                dec_op;
    logic               dec_illegal;
    logic               is_mul, is_div, a_neg, b_neg, div_zero, div_ovf, start_iter, accept;
    logic [XLEN-1:0]    mag_a, mag_b, single_res, fin_res, mul_addend, quo, rem;
    logic [SW-1:0]      shamt;
    logic [XLEN:0]      mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]  mul_next, div_next, prod_fix;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign busy     = (state != S_IDLE);
    assign shamt    = op_b[SW-1:0];

    // Decode alu_op/funct7/funct3 into an internal operation.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise an
        // unassigned path would infer a latch.
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case (alu_op)
            2'b00:   dec_op = OP_ADD;
            2'b01:   dec_op = OP_SUB;
            2'b11:   dec_op = base_op(funct3, funct7[5]);
            default: begin
                if (funct7 == 7'b0000000) begin
                    dec_op = base_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      dec_op = OP_SUB;
                    else if (funct3 == 3'b101) dec_op = OP_SRA;
                    else                       dec_illegal = 1'b1;
                end else if (funct7 == 7'b0000001 && M_EXT) begin
                    dec_op = op_t'({2'b10, funct3});
                end else begin
                    dec_illegal = 1'b1;
                end
            end
        endcase
    end

    // Operand signs/magnitudes, division fast paths and single-cycle result.
    always_comb begin
        is_mul     = !dec_illegal && (dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
        is_div     = !dec_illegal && (dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
        a_neg      = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a[XLEN-1];
        b_neg      = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
        mag_a      = a_neg ? -op_a : op_a;
        mag_b      = b_neg ? -op_b : op_b;
        div_zero   = (op_b == '0);
        div_ovf    = (dec_op inside {OP_DIV, OP_REM}) && (op_a == MIN_VAL) && (op_b == '1);
        start_iter = is_mul || (is_div && !div_zero && !div_ovf);
        case (dec_op)
            OP_ADD:          single_res = op_a + op_b;
            OP_SUB:          single_res = op_a - op_b;
            OP_SLL:          single_res = op_a << shamt;
            OP_SLT:          single_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:         single_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:          single_res = op_a ^ op_b;
            OP_SRL:          single_res = op_a >> shamt;
            OP_SRA:          single_res = $signed(op_a) >>> shamt;
            OP_OR:           single_res = op_a | op_b;
            OP_AND:          single_res = op_a & op_b;
            OP_DIV, OP_DIVU: single_res = div_zero ? '1 : MIN_VAL;
            OP_REM, OP_REMU: single_res = div_zero ? op_a : '0;
            default:         single_res = '0;
        endcase
        if (dec_illegal) single_res = '0;
    end

    // One shift-add or restoring-divide step, plus sign fix-up of the final value.
    always_comb begin
        mul_addend = acc[0] ? opnd : '0;
        mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc[XLEN-1:1]};
        div_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff   = div_shift - {1'b0, opnd};
        div_next   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
        prod_fix   = neg_res ? -acc : acc;
        quo        = acc[XLEN-1:0];
        rem        = acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:          fin_res = prod_fix[XLEN-1:0];
            OP_DIV, OP_DIVU: fin_res = neg_res ? -quo : quo;
            OP_REM, OP_REMU: fin_res = neg_rem ? -rem : rem;
            default:         fin_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Control FSM with registered result, zero, illegal and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // values from before the edge, independent of statement order.
        if (!rst_n) begin
            // NOTE: datapath registers are reset too; they are few and it keeps
            // the outputs deterministic after an aborted operation.
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            iter      <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && start_iter) begin
                        state     <= is_mul ? S_MUL : S_DIV;
                        op_q      <= dec_op;
                        iter      <= LAST_ITER;
                        acc       <= {{XLEN{1'b0}}, is_mul ? mag_b : mag_a};
                        opnd      <= is_mul ? mag_a : mag_b;
                        neg_res   <= a_neg ^ b_neg;
                        neg_rem   <= a_neg;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        result    <= single_res;
                        zero      <= (single_res == '0);
                        illegal   <= dec_illegal;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= (state == S_MUL) ? mul_next : div_next;
                    if (iter == '0) state <= S_FIN;
                    else            iter  <= iter - SW'(1);
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b1;
                    result    <= fin_res;
                    zero      <= (fin_res == '0);
                    illegal   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, ALU decode, mul/div results and
// latency, backpressure, back-to-back issue, reset abort and M_EXT=0 decode.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        in_ready, out_valid, zero, illegal, busy;
    logic [31:0] result;
    logic        n_in_ready, n_out_valid, n_zero, n_illegal, n_busy;
    logic [31:0] n_result;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [1:0]  aop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .M_EXT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .illegal(illegal), .busy(busy)
    );

    alu_exec_unit #(.XLEN(32), .M_EXT(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(n_out_valid), .out_ready(out_ready), .result(n_result), .zero(n_zero),
        .illegal(n_illegal), .busy(n_busy)
    );

    // Present one operation, wait (bounded) for in_ready, hold it over the accept edge,
    // then scramble the operands to show they are only sampled at accept.
    task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk);
        alu_op = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL issue_timeout: in_ready stayed %b for %0d cycles", in_ready, guard);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
    endtask

    // Count clock edges after the accept edge until out_valid is seen; 0 means the
    // result is already valid in the cycle following accept.
    task automatic wait_result(output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!out_valid && edges < 200) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, zero, illegal, busy} !== 4'b0000 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: out_valid=%b zero=%b illegal=%b busy=%b result=%h, expected all 0",
                     out_valid, zero, illegal, busy, result);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        vec_t v[$];
        int   edges;
        bit   busy_ok;
        v.push_back('{"add",        2'b00, 7'h00, 3'h0, 32'd5,         32'd7,         32'd12,        1'b0, 0});
        v.push_back('{"sub_zero",   2'b01, 7'h00, 3'h0, 32'h1234,      32'h1234,      32'h0,         1'b0, 0});
        v.push_back('{"sra",        2'b10, 7'h20, 3'h5, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 0});
        v.push_back('{"sll_shamt",  2'b10, 7'h00, 3'h1, 32'h1,         32'h24,        32'h10,        1'b0, 0});
        v.push_back('{"slt",        2'b10, 7'h00, 3'h2, 32'hFFFF_FFFF, 32'd1,         32'h1,         1'b0, 0});
        v.push_back('{"sltu",       2'b10, 7'h00, 3'h3, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0, 0});
        v.push_back('{"xor",        2'b10, 7'h00, 3'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 0});
        v.push_back('{"srl",        2'b10, 7'h00, 3'h5, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 0});
        v.push_back('{"or",         2'b10, 7'h00, 3'h6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 0});
        v.push_back('{"and",        2'b10, 7'h00, 3'h7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 0});
        v.push_back('{"srai",       2'b11, 7'h20, 3'h5, 32'h8000_0000, 32'd1,         32'hC000_0000, 1'b0, 0});
        v.push_back('{"addi_f7",    2'b11, 7'h20, 3'h0, 32'd3,         32'd4,         32'd7,         1'b0, 0});
        v.push_back('{"ls_add_wrap",2'b00, 7'h20, 3'h7, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0, 0});
        v.push_back('{"br_sub",     2'b01, 7'h7F, 3'h5, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 0});
        v.push_back('{"ill_f3",     2'b10, 7'h20, 3'h1, 32'd9,         32'd9,         32'h0,         1'b1, 0});
        v.push_back('{"ill_f7",     2'b10, 7'h7F, 3'h0, 32'd9,         32'd9,         32'h0,         1'b1, 0});
        foreach (v[i]) begin
            issue(v[i].aop, v[i].f7, v[i].f3, v[i].a, v[i].b);
            wait_result(edges, busy_ok);
            tests_run++;
            if (result !== v[i].exp || zero !== (v[i].exp == 32'h0) || illegal !== v[i].ill) begin
                tests_failed++;
                $display("FAIL %s: result=%h zero=%b illegal=%b, expected result=%h zero=%b illegal=%b",
                         v[i].name, result, zero, illegal, v[i].exp, v[i].exp == 32'h0, v[i].ill);
            end
            tests_run++;
            if (edges != v[i].lat) begin
                tests_failed++;
                $display("FAIL %s_latency: %0d edges after accept, expected %0d", v[i].name, edges, v[i].lat);
            end
        end
    endtask

    task automatic test_muldiv;
        vec_t v[$];
        int   edges;
        bit   busy_ok;
        v.push_back('{"mulh",       2'b10, 7'h01, 3'h1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 33});
        v.push_back('{"mul",        2'b10, 7'h01, 3'h0, 32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0, 33});
        v.push_back('{"mul_neg",    2'b10, 7'h01, 3'h0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, 33});
        v.push_back('{"mulhu",      2'b10, 7'h01, 3'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
        v.push_back('{"mulhsu",     2'b10, 7'h01, 3'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33});
        v.push_back('{"mulh_min",   2'b10, 7'h01, 3'h1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33});
        v.push_back('{"div",        2'b10, 7'h01, 3'h4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33});
        v.push_back('{"rem",        2'b10, 7'h01, 3'h6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33});
        v.push_back('{"divu",       2'b10, 7'h01, 3'h5, 32'd100,       32'd7,         32'd14,        1'b0, 33});
        v.push_back('{"remu",       2'b10, 7'h01, 3'h7, 32'd100,       32'd7,         32'd2,         1'b0, 33});
        v.push_back('{"rem_negdvs", 2'b10, 7'h01, 3'h6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 33});
        v.push_back('{"div_negdvs", 2'b10, 7'h01, 3'h4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33});
        v.push_back('{"divu_by0",   2'b10, 7'h01, 3'h5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1'b0, 0});
        v.push_back('{"rem_by0",    2'b10, 7'h01, 3'h6, 32'h55,        32'd0,         32'h55,        1'b0, 0});
        v.push_back('{"div_ovf",    2'b10, 7'h01, 3'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0});
        v.push_back('{"rem_ovf",    2'b10, 7'h01, 3'h6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 0});
        v.push_back('{"divu_big",   2'b10, 7'h01, 3'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 33});
        foreach (v[i]) begin
            issue(v[i].aop, v[i].f7, v[i].f3, v[i].a, v[i].b);
            wait_result(edges, busy_ok);
            tests_run++;
            if (result !== v[i].exp || zero !== (v[i].exp == 32'h0) || illegal !== v[i].ill) begin
                tests_failed++;
                $display("FAIL %s: result=%h zero=%b illegal=%b, expected result=%h zero=%b illegal=%b",
                         v[i].name, result, zero, illegal, v[i].exp, v[i].exp == 32'h0, v[i].ill);
            end
            tests_run++;
            if (edges != v[i].lat) begin
                tests_failed++;
                $display("FAIL %s_latency: %0d edges after accept, expected %0d", v[i].name, edges, v[i].lat);
            end
            if (v[i].lat != 0) begin
                tests_run++;
                if (!busy_ok) begin
                    tests_failed++;
                    $display("FAIL %s_busy: busy/in_ready not 1/0 throughout, expected busy=1 in_ready=0", v[i].name);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        alu_op = 2'b00; funct7 = '0; funct3 = '0; op_a = 32'd1; op_b = 32'd2;
        @(posedge clk); #1;
        op_a = 32'd10; op_b = 32'd20;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd3) begin
            tests_failed++;
            $display("FAIL b2b_first: out_valid=%b result=%h, expected 1 and %h", out_valid, result, 32'd3);
        end
        @(posedge clk); #1;
        alu_op = 2'b01; op_a = 32'd50; op_b = 32'd8;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd30) begin
            tests_failed++;
            $display("FAIL b2b_second: out_valid=%b result=%h, expected 1 and %h", out_valid, result, 32'd30);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd42) begin
            tests_failed++;
            $display("FAIL b2b_third: out_valid=%b result=%h, expected 1 and %h", out_valid, result, 32'd42);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        alu_op = 2'b00; funct7 = '0; funct3 = '0; op_a = 32'd1; op_b = 32'd2;
        @(posedge clk); #1;
        op_a = 32'd100; op_b = 32'd23;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: out_valid=%b result=%h in_ready=%b, expected 1 %h 0",
                         c, out_valid, result, in_ready, 32'd3);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd123) begin
            tests_failed++;
            $display("FAIL backpressure_release: out_valid=%b result=%h, expected 1 and %h", out_valid, result, 32'd123);
        end
    endtask

    task automatic test_reset_mid_div;
        int  edges;
        bit  busy_ok;
        issue(2'b10, 7'h01, 3'h4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_div_busy: busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_abort: out_valid=%b busy=%b in_ready=%b, expected 0 0 1", out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 7'h00, 3'h0, 32'd5, 32'd7);
        wait_result(edges, busy_ok);
        tests_run++;
        if (result !== 32'd12 || edges != 0) begin
            tests_failed++;
            $display("FAIL after_reset_add: result=%h edges=%0d, expected %h and 0", result, edges, 32'd12);
        end
    endtask

    task automatic test_no_mext;
        int guard = 0;
        issue(2'b10, 7'h01, 3'h0, 32'd6, 32'd7);
        @(negedge clk);
        tests_run++;
        if (n_out_valid !== 1'b1 || n_illegal !== 1'b1 || n_result !== 32'h0 || n_zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_mext_illegal: out_valid=%b illegal=%b result=%h zero=%b, expected 1 1 0 1",
                     n_out_valid, n_illegal, n_result, n_zero);
        end
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd42 || illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL mext_mul: out_valid=%b result=%h illegal=%b, expected 1 %h 0", out_valid, result, illegal, 32'd42);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        test_no_mext();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
